sum_accum4: RTL and testbench
=============================

SUM_ACCUM4 -- requirements
Module: sum_accum4

Interface
REQ-001 The block SHALL have parameter NSAMP, default 4, meaning number of 4-bit sums accumulated per result (legal range 1..255).
REQ-002 The block SHALL have parameter AW, default 8, meaning accumulator and result width in bits.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1, meaning in_data holds a valid 4-bit sum from the upstream adder.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-007 The block SHALL have port in_data, input, 4, meaning the unsigned sum sample.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_sum and out_ovf are valid.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the downstream consumer takes the result.
REQ-010 The block SHALL have port out_sum, output, AW, meaning the accumulated total modulo 2^AW.
REQ-011 The block SHALL have port out_ovf, output, 1, meaning a carry out of bit AW-1 occurred during this accumulation.
REQ-012 The block SHALL have port busy, output, 1, meaning at least one sample is accepted but no result is handed off yet.

Function
REQ-013 The block SHALL implement FSM states IDLE, ACC, HOLD.
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both high at a rising clk edge.
REQ-015 The block SHALL drive in_ready high in IDLE and ACC and low in HOLD.
REQ-016 In IDLE, a transfer SHALL load acc = zero-extended in_data, set cnt = 1, clear ovf, and move to ACC (or to HOLD if NSAMP == 1).
REQ-017 In ACC, a transfer SHALL set acc = acc + zero-extended in_data (AW bits, wrap), set ovf sticky on carry out, and increment cnt.
REQ-018 When the transfer that makes cnt equal NSAMP occurs, the block SHALL enter HOLD on the next edge.
REQ-019 The block SHALL assert out_valid exactly in HOLD, one cycle after the NSAMP-th transfer, with out_sum = acc and out_ovf = ovf.
REQ-020 The block SHALL hold out_sum and out_ovf stable while out_valid is high and out_ready is low.
REQ-021 On out_valid and out_ready both high, the block SHALL return to IDLE on that edge; it SHALL not accept new input in that same cycle.
REQ-022 When in_valid is low, the block SHALL leave acc, cnt and state unchanged.
REQ-023 The block SHALL drive busy high in ACC and HOLD and low in IDLE.
REQ-024 out_sum and out_ovf SHALL read 0 whenever out_valid is low.

Reset
REQ-025 While rst is high at a clk edge, the block SHALL enter IDLE and clear acc, cnt and ovf, overriding any simultaneous transfer.
REQ-026 After reset, outputs SHALL be in_ready=1, out_valid=0, out_sum=0, out_ovf=0, busy=0.
REQ-027 A reset in ACC or HOLD SHALL discard the partial or pending result without emitting it.

Structure
REQ-028 Package sum_accum_pkg SHALL hold the state enum (IDLE, ACC, HOLD), the input width constant 4, and the default AW.
REQ-029 cnt width SHALL be clog2(NSAMP+1), computed in the module.
REQ-030 The AW-bit adder with carry out SHALL be the combinational sub-module acc_add, instanced once.

Verification
REQ-031 NSAMP=4: samples 1,2,3,4 back-to-back -> out_valid on the cycle after the 4th transfer, out_sum=10, out_ovf=0.
REQ-032 NSAMP=4: samples 15,15,15,15 with in_valid gaps, out_ready held low 3 cycles -> out_sum=60 stable throughout, in_ready=0 until handoff.
REQ-033 NSAMP=20: twenty samples of 15 -> out_sum=44 (300 mod 256), out_ovf=1.
REQ-034 NSAMP=4: rst pulsed after 2 transfers (3,5) -> no out_valid; then 1,1,1,1 -> out_sum=4.
REQ-035 NSAMP=1: sample 7 with out_ready=1 -> out_valid one cycle later with out_sum=7, IDLE on the following cycle.
REQ-036 in_valid held high across the handoff cycle -> that cycle's in_data is not accepted; the next accumulation begins on the following cycle.

Source files
------------

// File: rtl/sum_accum_pkg.sv
// Shared types and constants for the 4-bit-sum accumulator.
package sum_accum_pkg;

  localparam int IN_W       = 4;
  localparam int AW_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ACC  = ST_ACC,
    HOLD = ST_HOLD
  } state_e;

endpackage

// File: rtl/sum_accum4_acc_add.sv
// AW-bit unsigned adder with carry out, used for every accumulation step.
import sum_accum_pkg::*;

module acc_add #(
  parameter int AW = AW_DEFAULT
) (
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/sum_accum4.sv
// Accumulates NSAMP unsigned 4-bit sums into one AW-bit result with sticky overflow.
//   state | meaning
//   IDLE  | no sample taken; next transfer starts a new accumulation
//   ACC   | partial total held; more samples expected
//   HOLD  | result presented on out_*; input stalled until handoff
import sum_accum_pkg::*;

module sum_accum4 #(
  parameter int NSAMP = 4,
  parameter int AW    = AW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AW-1:0]   out_sum,
  output logic            out_ovf,
  output logic            busy
);

  localparam int             CW       = $clog2(NSAMP + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(NSAMP);

  state_e        state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          xfer;
  logic [AW-1:0] add_a;
  logic [AW-1:0] add_b;
  logic [AW-1:0] add_sum;
  logic          add_carry;
  logic [CW-1:0] cnt_nxt;

  assign in_ready = (state != HOLD);
  assign xfer     = in_valid & in_ready;

  // Starting from zero in IDLE lets one adder cover both load and accumulate.
  assign add_a   = (state == IDLE) ? '0 : acc;
  assign add_b   = AW'(in_data);
  assign cnt_nxt = (state == IDLE) ? CW'(1) : cnt + 1'b1;

  acc_add #(.AW(AW)) u_add (
    .a     (add_a),
    .b     (add_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (xfer) begin
            acc   <= add_sum;
            cnt   <= cnt_nxt;
            ovf   <= (ovf & (state == ACC)) | add_carry;
            state <= (cnt_nxt == CNT_LAST) ? HOLD : ACC;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == HOLD);
  assign out_sum   = out_valid ? acc : '0;
  assign out_ovf   = out_valid & ovf;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sum_accum4.sv
// Bench for sum_accum4: three instances (NSAMP 4, 20, 1) checked against a sample-list model.
module tb_sum_accum4;

  logic       clk;
  logic       rst_v      [3];
  logic       in_valid_v [3];
  logic [3:0] in_data_v  [3];
  logic       out_ready_v[3];
  logic       in_ready_o [3];
  logic       out_valid_o[3];
  logic [7:0] out_sum_o  [3];
  logic       out_ovf_o  [3];
  logic       busy_o     [3];

  int vectors    = 0;
  int miscompares = 0;

  int nsamp [3] = '{4, 20, 1};
  int m_cnt [3];
  int m_sum [3];
  bit m_pend[3];

  sum_accum4 #(.NSAMP(4), .AW(8)) u_d0 (
    .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_o[0]),
    .in_data(in_data_v[0]), .out_valid(out_valid_o[0]), .out_ready(out_ready_v[0]),
    .out_sum(out_sum_o[0]), .out_ovf(out_ovf_o[0]), .busy(busy_o[0]));

  sum_accum4 #(.NSAMP(20), .AW(8)) u_d1 (
    .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_o[1]),
    .in_data(in_data_v[1]), .out_valid(out_valid_o[1]), .out_ready(out_ready_v[1]),
    .out_sum(out_sum_o[1]), .out_ovf(out_ovf_o[1]), .busy(busy_o[1]));

  sum_accum4 #(.NSAMP(1), .AW(8)) u_d2 (
    .clk(clk), .rst(rst_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_o[2]),
    .in_data(in_data_v[2]), .out_valid(out_valid_o[2]), .out_ready(out_ready_v[2]),
    .out_sum(out_sum_o[2]), .out_ovf(out_ovf_o[2]), .busy(busy_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit   rst;
    bit   v;
    int   d;
    bit   ordy;
    bit   e_valid;
    int   e_sum;
    bit   e_ovf;
    bit   e_rdy;
    bit   e_busy;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input int i, input bit r, input bit v, input int d, input bit o);
    rst_v[i]       = r;
    in_valid_v[i]  = v;
    in_data_v[i]   = 4'(d);
    out_ready_v[i] = o;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare all instances.
  task automatic tick();
    bit r[3], v[3], o[3];
    int d[3];
    for (int i = 0; i < 3; i++) begin
      r[i] = rst_v[i]; v[i] = in_valid_v[i]; o[i] = out_ready_v[i]; d[i] = int'(in_data_v[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (r[i]) begin
        m_cnt[i] = 0; m_sum[i] = 0; m_pend[i] = 0;
      end else if (m_pend[i]) begin
        if (o[i]) begin
          m_cnt[i] = 0; m_sum[i] = 0; m_pend[i] = 0;
        end
      end else if (v[i]) begin
        m_sum[i] += d[i];
        m_cnt[i]++;
        if (m_cnt[i] == nsamp[i]) m_pend[i] = 1;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d in_ready", i),  int'(in_ready_o[i]),  int'(!m_pend[i]));
      chk($sformatf("d%0d out_valid", i), int'(out_valid_o[i]), int'(m_pend[i]));
      chk($sformatf("d%0d busy", i),      int'(busy_o[i]),      int'(m_pend[i] || m_cnt[i] > 0));
      chk($sformatf("d%0d out_sum", i),   int'(out_sum_o[i]),   m_pend[i] ? (m_sum[i] % 256) : 0);
      chk($sformatf("d%0d out_ovf", i),   int'(out_ovf_o[i]),   int'(m_pend[i] && m_sum[i] > 255));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      set_in(i, 1'b1, 1'b0, 0, 1'b0);
      m_cnt[i] = 0; m_sum[i] = 0; m_pend[i] = 0;
    end

    //              rst v  d  ordy  valid sum ovf rdy busy
    tbl[0] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1, 1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 2, 1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 3, 1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 4, 1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 0,  1'b0, 1'b1, 1'b0};

    tick();
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 1'b0, 0, 1'b0);
    tick();

    // Back-to-back 1,2,3,4 on the NSAMP=4 instance
    for (int k = 0; k < 7; k++) begin
      set_in(0, tbl[k].rst, tbl[k].v, tbl[k].d, tbl[k].ordy);
      tick();
      chk($sformatf("tbl%0d out_valid", k), int'(out_valid_o[0]), int'(tbl[k].e_valid));
      chk($sformatf("tbl%0d out_sum", k),   int'(out_sum_o[0]),   tbl[k].e_sum);
      chk($sformatf("tbl%0d out_ovf", k),   int'(out_ovf_o[0]),   int'(tbl[k].e_ovf));
      chk($sformatf("tbl%0d in_ready", k),  int'(in_ready_o[0]),  int'(tbl[k].e_rdy));
      chk($sformatf("tbl%0d busy", k),      int'(busy_o[0]),      int'(tbl[k].e_busy));
    end

    // 15 x4 with gaps, consumer stalls three cycles
    set_in(0, 0, 1, 15, 0); tick();
    set_in(0, 0, 0, 0, 0);  tick();
    set_in(0, 0, 1, 15, 0); tick();
    set_in(0, 0, 0, 0, 0);  tick();
    set_in(0, 0, 1, 15, 0); tick();
    tick();
    chk("stall out_valid", int'(out_valid_o[0]), 1);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 0, 1, 3, 0); tick();
      chk("stall out_sum", int'(out_sum_o[0]), 60);
      chk("stall in_ready", int'(in_ready_o[0]), 0);
    end
    set_in(0, 0, 0, 0, 1); tick();
    chk("stall handoff", int'(out_valid_o[0]), 0);

    // Twenty 15s on NSAMP=20: wraps to 44 with overflow
    for (int k = 0; k < 20; k++) begin
      set_in(1, 0, 1, 15, 0); tick();
    end
    chk("n20 out_sum", int'(out_sum_o[1]), 44);
    chk("n20 out_ovf", int'(out_ovf_o[1]), 1);
    set_in(1, 0, 0, 0, 1); tick();
    chk("n20 handoff", int'(out_valid_o[1]), 0);

    // Reset mid-accumulation discards the partial total
    set_in(0, 0, 1, 3, 0); tick();
    set_in(0, 0, 1, 5, 0); tick();
    set_in(0, 1, 1, 6, 1); tick();
    chk("rst busy", int'(busy_o[0]), 0);
    chk("rst out_valid", int'(out_valid_o[0]), 0);
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 1, 1, 0); tick();
    end
    chk("post-rst out_sum", int'(out_sum_o[0]), 4);
    set_in(0, 0, 0, 0, 1); tick();

    // NSAMP=1: single sample straight to HOLD, back to IDLE next cycle
    set_in(2, 0, 1, 7, 1); tick();
    chk("n1 out_valid", int'(out_valid_o[2]), 1);
    chk("n1 out_sum", int'(out_sum_o[2]), 7);
    set_in(2, 0, 0, 0, 1); tick();
    chk("n1 idle valid", int'(out_valid_o[2]), 0);
    chk("n1 idle busy", int'(busy_o[2]), 0);

    // in_valid held across handoff: that sample must be dropped
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 1, 2, 0); tick();
    end
    chk("ho out_sum", int'(out_sum_o[0]), 8);
    set_in(0, 0, 1, 9, 1); tick();
    chk("ho busy", int'(busy_o[0]), 0);
    chk("ho in_ready", int'(in_ready_o[0]), 1);
    for (int k = 0; k < 4; k++) begin
      set_in(0, 0, 1, 1, 0); tick();
    end
    chk("ho next sum", int'(out_sum_o[0]), 4);
    set_in(0, 0, 0, 0, 1); tick();

    // Randomized traffic on all three instances against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 3; i++) begin
        set_in(i, ($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
               int'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
